// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and issues one instruction read at a time,
// buffering {pc, instr} for decode. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_addr,
    output logic        read_instr,
    input  logic [31:0] instr,
    input  logic        instr_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        out_misaligned,
`endif
    input  logic        out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        drop_q, drop_d;

    logic [31:0] pc_mem_q  [FIFO_DEPTH];
    logic [31:0] ins_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [AW:0]   occ_q;

    logic        pop, push, trap, slot_free;
    logic [AW:0] occ_nxt;
    logic [31:0] tgt, pc_nxt;

    assign tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap = redirect & (redirect_pc[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = (state_q == WAIT) & req_q & instr_ready
                     & ~drop_q & ~redirect;
    assign occ_nxt   = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    assign slot_free = (occ_nxt < DEPTH_C);
    assign pc_nxt    = drop_q ? pc_q : addr_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d    = tgt;
            state_d = WAIT;
            if (req_q && !instr_ready) begin
                drop_d = 1'b1;
            end else begin
                drop_d = 1'b0;
                req_d  = 1'b1;
                addr_d = tgt;
            end
            if (trap) begin
                state_d = HALT;
                if (!(req_q && !instr_ready)) req_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (slot_free) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (instr_ready) begin
                        drop_d = 1'b0;
                        pc_d   = pc_nxt;
                        if (slot_free) begin
                            addr_d = pc_nxt;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                HALT: begin
                    // Let a killed read finish before going quiet
                    if (req_q && instr_ready) begin
                        req_d  = 1'b0;
                        drop_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
        end else if (redirect) begin
            rptr_q <= '0;
            wptr_q <= trap ? AW'(1) : '0;
            occ_q  <= trap ? (AW+1)'(1) : '0;
        end else begin
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (push) wptr_q <= wptr_q + AW'(1);
            occ_q <= occ_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (redirect && trap) begin
            pc_mem_q[0]  <= redirect_pc;
            ins_mem_q[0] <= NOP;
        end else if (push) begin
            pc_mem_q[wptr_q]  <= addr_q;
            ins_mem_q[wptr_q] <= instr;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (redirect && trap) begin
            mis_mem_q[0] <= 1'b1;
        end else if (push) begin
            mis_mem_q[wptr_q] <= 1'b0;
        end
    end

    assign out_misaligned = out_valid & mis_mem_q[rptr_q];
`endif

    assign pc_addr    = addr_q;
    assign read_instr = req_q;
    assign out_pc     = out_valid ? pc_mem_q[rptr_q]  : '0;
    assign out_instr  = out_valid ? ins_mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirects,
// wrap-around and (optionally) the misaligned-redirect trap entry.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_addr;
    logic        read_instr;
    logic [31:0] instr;
    logic        instr_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        out_misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_addr     (pc_addr),
        .read_instr  (read_instr),
        .instr       (instr),
        .instr_ready (instr_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .out_misaligned (out_misaligned),
`endif
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory answers with the inverted address as the instruction word
    task automatic mem(input logic rdy);
        instr_ready = rdy;
        instr       = ~pc_addr;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        instr       = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();
        chk("rst_read",  {31'd0, read_instr}, 32'd0);
        chk("rst_addr",  pc_addr, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc",    out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);

        // Streaming with zero-wait memory
        step();
        chk("t1_read0", {31'd0, read_instr}, 32'd1);
        chk("t1_addr0", pc_addr, 32'h0);
        chk("t1_valid0", {31'd0, out_valid}, 32'd0);
        mem(1'b1);
        step();
        chk("t1_valid1", {31'd0, out_valid}, 32'd1);
        chk("t1_opc1",  out_pc, 32'h0);
        chk("t1_oin1",  out_instr, 32'hFFFF_FFFF);
        chk("t1_addr1", pc_addr, 32'h4);
        mem(1'b1);
        step();
        chk("t1_opc2",  out_pc, 32'h4);
        chk("t1_oin2",  out_instr, 32'hFFFF_FFFB);
        chk("t1_addr2", pc_addr, 32'h8);
        mem(1'b1);
        step();
        chk("t1_opc3",  out_pc, 32'h8);
        chk("t1_val3",  {31'd0, out_valid}, 32'd1);
        chk("t1_addr3", pc_addr, 32'hC);

        // Backpressure fills the two-entry buffer
        out_ready = 1'b0;
        do_reset();
        step();
        chk("t2_addr0", pc_addr, 32'h0);
        mem(1'b1);
        step();
        chk("t2_opc0",  out_pc, 32'h0);
        chk("t2_addr1", pc_addr, 32'h4);
        chk("t2_read1", {31'd0, read_instr}, 32'd1);
        mem(1'b1);
        step();
        chk("t2_read2", {31'd0, read_instr}, 32'd0);
        chk("t2_hold2", out_pc, 32'h0);
        mem(1'b0);
        step();
        chk("t2_read3", {31'd0, read_instr}, 32'd0);
        chk("t2_hold3", out_pc, 32'h0);
        chk("t2_vld3",  {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("t2_opc4",  out_pc, 32'h4);
        chk("t2_read4", {31'd0, read_instr}, 32'd1);
        chk("t2_addr4", pc_addr, 32'h8);
        step();
        chk("t2_vld5",  {31'd0, out_valid}, 32'd0);
        chk("t2_addr5", pc_addr, 32'h8);

        // Redirect while the read to 0x8 is still waiting
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("t3_addr0", pc_addr, 32'h8);
        chk("t3_read0", {31'd0, read_instr}, 32'd1);
        chk("t3_vld0",  {31'd0, out_valid}, 32'd0);
        step();
        chk("t3_addr1", pc_addr, 32'h8);
        mem(1'b1);
        step();
        chk("t3_vld2",  {31'd0, out_valid}, 32'd0);
        chk("t3_addr2", pc_addr, 32'h100);
        chk("t3_read2", {31'd0, read_instr}, 32'd1);
        mem(1'b1);
        step();
        chk("t3_vld3",  {31'd0, out_valid}, 32'd1);
        chk("t3_opc3",  out_pc, 32'h100);
        chk("t3_oin3",  out_instr, 32'hFFFF_FEFF);
        chk("t3_addr3", pc_addr, 32'h104);

        // Steer to 0xC, then redirect on the cycle 0xC completes
        redirect    = 1'b1;
        redirect_pc = 32'hC;
        mem(1'b0);
        step();
        redirect = 1'b0;
        chk("t4_vld0",  {31'd0, out_valid}, 32'd0);
        chk("t4_addr0", pc_addr, 32'h104);
        mem(1'b1);
        step();
        chk("t4_addr1", pc_addr, 32'hC);
        chk("t4_vld1",  {31'd0, out_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        mem(1'b1);
        step();
        redirect = 1'b0;
        chk("t4_addr2", pc_addr, 32'h200);
        chk("t4_read2", {31'd0, read_instr}, 32'd1);
        chk("t4_vld2",  {31'd0, out_valid}, 32'd0);
        mem(1'b1);
        step();
        chk("t4_vld3",  {31'd0, out_valid}, 32'd1);
        chk("t4_opc3",  out_pc, 32'h200);
        chk("t4_oin3",  out_instr, 32'hFFFF_FDFF);
        chk("t4_addr3", pc_addr, 32'h204);

        // Last word of the address space wraps to zero
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        mem(1'b1);
        step();
        redirect = 1'b0;
        chk("t5_vld0",  {31'd0, out_valid}, 32'd0);
        chk("t5_addr0", pc_addr, 32'hFFFF_FFFC);
        mem(1'b1);
        step();
        chk("t5_vld1",  {31'd0, out_valid}, 32'd1);
        chk("t5_opc1",  out_pc, 32'hFFFF_FFFC);
        chk("t5_oin1",  out_instr, 32'h0000_0003);
        chk("t5_addr1", pc_addr, 32'h0);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        mem(1'b1);
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_vld0",  {31'd0, out_valid}, 32'd1);
        chk("t6_opc0",  out_pc, 32'h102);
        chk("t6_oin0",  out_instr, 32'h0000_0013);
        chk("t6_mis0",  {31'd0, out_misaligned}, 32'd1);
        chk("t6_read0", {31'd0, read_instr}, 32'd0);
        mem(1'b0);
        step();
        chk("t6_vld1",  {31'd0, out_valid}, 32'd0);
        chk("t6_read1", {31'd0, read_instr}, 32'd0);
        step();
        chk("t6_read2", {31'd0, read_instr}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("t6_read3", {31'd0, read_instr}, 32'd1);
        chk("t6_addr3", pc_addr, 32'h200);
        mem(1'b1);
        step();
        chk("t6_opc4",  out_pc, 32'h200);
        chk("t6_mis4",  {31'd0, out_misaligned}, 32'd0);
`else
        chk("t6_addr0", pc_addr, 32'h100);
        chk("t6_vld0",  {31'd0, out_valid}, 32'd0);
        mem(1'b1);
        step();
        chk("t6_opc1",  out_pc, 32'h100);
        chk("t6_addr1", pc_addr, 32'h104);
`endif

        // Reset mid-request: late ready must not produce output
        mem(1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem(1'b1);
        chk("t7_read0", {31'd0, read_instr}, 32'd0);
        step();
        chk("t7_vld1",  {31'd0, out_valid}, 32'd0);
        chk("t7_addr1", pc_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
